// File: rtl/line_backing_memory_if.sv
// Request/response bus between the data cache and line_backing_memory.
// The err signal exists only when LINE_MEM_ERR_EN is defined.
interface line_backing_memory_if #(
    parameter int LINE_SIZE = 16
);
    logic                   is_input_valid;
    logic [31:0]            addr;
    logic                   mem_read;
    logic                   mem_write;
    logic [LINE_SIZE*8-1:0] din;
    logic                   is_output_valid;
    logic [LINE_SIZE*8-1:0] dout;
    logic                   mem_ready;
`ifdef LINE_MEM_ERR_EN
    logic                   err;

    modport master (
        output is_input_valid, addr, mem_read, mem_write, din,
        input  is_output_valid, dout, mem_ready, err
    );

    modport slave (
        input  is_input_valid, addr, mem_read, mem_write, din,
        output is_output_valid, dout, mem_ready, err
    );
`else
    modport master (
        output is_input_valid, addr, mem_read, mem_write, din,
        input  is_output_valid, dout, mem_ready
    );

    modport slave (
        input  is_input_valid, addr, mem_read, mem_write, din,
        output is_output_valid, dout, mem_ready
    );
`endif
endinterface

// File: rtl/line_backing_memory.sv
// Line-granular backing store: one whole-line read or write at a time, completed after DELAY cycles.
// Define LINE_MEM_ERR_EN to add the err pulse and out-of-range request handling.
module line_backing_memory #(
    parameter int LINE_SIZE = 16,
    parameter int NUM_LINES = 256,
    parameter int DELAY     = 50
) (
    input  logic                  clk,
    input  logic                  reset,
    line_backing_memory_if.slave  bus
);
    localparam int LINE_W = LINE_SIZE * 8;
    localparam int OFF_W  = $clog2(LINE_SIZE);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int CNT_W  = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_write_q, is_write_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [LINE_W-1:0]   dout_q, dout_d;
    logic                mem_we;
    logic [LINE_W-1:0]   line_mem [NUM_LINES];

    logic                req_legal;
    logic [IDX_W-1:0]    req_idx;
    logic                unused_addr;

`ifdef LINE_MEM_ERR_EN
    logic                oor_q, oor_d;
    logic                err_q, err_d;
    logic                addr_oor;

    assign addr_oor = (bus.addr >> (OFF_W + IDX_W)) != 32'd0;
`endif

    assign req_legal   = bus.mem_read ^ bus.mem_write;
    assign req_idx     = bus.addr[OFF_W +: IDX_W];
    // Offset bits (and upper bits in the default build) are intentionally ignored.
    assign unused_addr = ^bus.addr;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        dout_d     = dout_q;
        mem_we     = 1'b0;
`ifdef LINE_MEM_ERR_EN
        oor_d      = oor_q;
        err_d      = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.is_input_valid && req_legal) begin
                    is_write_d = bus.mem_write;
                    idx_d      = req_idx;
                    wdata_d    = bus.din;
                    cnt_d      = CNT_LOAD;
                    state_d    = BUSY;
`ifdef LINE_MEM_ERR_EN
                    oor_d      = addr_oor;
`endif
                end
`ifdef LINE_MEM_ERR_EN
                err_d = bus.is_input_valid && (!req_legal || addr_oor);
`endif
            end

            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (is_write_q) begin
`ifdef LINE_MEM_ERR_EN
                    mem_we  = !oor_q;
`else
                    mem_we  = 1'b1;
`endif
                    state_d = IDLE;
                end else begin
`ifdef LINE_MEM_ERR_EN
                    dout_d  = oor_q ? '0 : line_mem[idx_q];
`else
                    dout_d  = line_mem[idx_q];
`endif
                    state_d = RESP;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            dout_q     <= '0;
`ifdef LINE_MEM_ERR_EN
            oor_q      <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            dout_q     <= dout_d;
`ifdef LINE_MEM_ERR_EN
            oor_q      <= oor_d;
            err_q      <= err_d;
`endif
        end
    end

    // NOTE: the line array is deliberately left out of reset; contents survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            line_mem[idx_q] <= wdata_q;
        end
    end

    assign bus.mem_ready       = (state_q == IDLE);
    assign bus.is_output_valid = (state_q == RESP);
    assign bus.dout            = dout_q;
`ifdef LINE_MEM_ERR_EN
    assign bus.err             = err_q;
`endif

endmodule

// File: tb/tb_line_backing_memory.sv
// Directed self-checking bench for line_backing_memory (LINE_SIZE=16, NUM_LINES=256, DELAY=4).
// Checks for err are compiled in only when LINE_MEM_ERR_EN is defined.
module tb_line_backing_memory;
    localparam int LS  = 16;
    localparam int NL  = 256;
    localparam int DLY = 4;
    localparam int W   = LS * 8;

    localparam logic [W-1:0] PAT_A5 = {LS{8'hA5}};
    localparam logic [W-1:0] PAT_B  = {LS{8'h3C}};
    localparam logic [W-1:0] PAT_C  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [W-1:0] PAT_D  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [W-1:0] PAT_E  = 128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    line_backing_memory_if #(.LINE_SIZE(LS)) bus();

    line_backing_memory #(
        .LINE_SIZE(LS),
        .NUM_LINES(NL),
        .DELAY    (DLY)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic rd, input logic wr, input logic [W-1:0] d);
        bus.is_input_valid = 1'b1;
        bus.addr           = a;
        bus.mem_read       = rd;
        bus.mem_write      = wr;
        bus.din            = d;
    endtask

    task automatic idle_bus;
        bus.is_input_valid = 1'b0;
        bus.addr           = '0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.din            = '0;
    endtask

    // Issues a read and watches a bounded window; lat is edges after accept, -1 if no pulse.
    task automatic do_read(input logic [31:0] a, output logic [W-1:0] data, output int lat, output int pulses);
        lat    = -1;
        pulses = 0;
        data   = '0;
        drive(a, 1'b1, 1'b0, '0);
        tick();
        idle_bus();
        for (int e = 1; e <= DLY + 4; e++) begin
            tick();
            if (bus.is_output_valid === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat  = e;
                    data = bus.dout;
                end
            end
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [W-1:0] d);
        drive(a, 1'b0, 1'b1, d);
        tick();
        idle_bus();
        repeat (DLY) tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.mem_ready); end
        checks++; if (bus.is_output_valid !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b want 0", bus.is_output_valid); end
        checks++; if (bus.dout !== '0) begin errors++; $display("FAIL reset_dout: got %h want 0", bus.dout); end
`ifdef LINE_MEM_ERR_EN
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
`endif
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.mem_ready); end
    endtask

    task automatic test_write_read;
        drive(32'h50, 1'b0, 1'b1, PAT_A5);
        tick();
        idle_bus();
        for (int e = 0; e < 4; e++) begin
            checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL wr_busy_ready_e%0d: got %b want 0", e, bus.mem_ready); end
            tick();
        end
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL wr_done_ready_e4: got %b want 1", bus.mem_ready); end
        drive(32'h5C, 1'b1, 1'b0, '0);
        tick();
        idle_bus();
        for (int e = 5; e < 9; e++) begin
            checks++; if (bus.is_output_valid !== 1'b0) begin errors++; $display("FAIL rd_early_ov_e%0d: got %b want 0", e, bus.is_output_valid); end
            checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL rd_busy_ready_e%0d: got %b want 0", e, bus.mem_ready); end
            tick();
        end
        checks++; if (bus.is_output_valid !== 1'b1) begin errors++; $display("FAIL rd_ov_e9: got %b want 1", bus.is_output_valid); end
        checks++; if (bus.dout !== PAT_A5) begin errors++; $display("FAIL rd_dout_e9: got %h want %h", bus.dout, PAT_A5); end
        checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL rd_resp_ready_e9: got %b want 0", bus.mem_ready); end
        tick();
        checks++; if (bus.is_output_valid !== 1'b0) begin errors++; $display("FAIL rd_ov_e10: got %b want 0", bus.is_output_valid); end
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL rd_ready_e10: got %b want 1", bus.mem_ready); end
        checks++; if (bus.dout !== PAT_A5) begin errors++; $display("FAIL rd_dout_hold_e10: got %h want %h", bus.dout, PAT_A5); end
    endtask

    task automatic test_reset_abort;
        logic [W-1:0] data;
        int lat, pulses;
        drive(32'h30, 1'b0, 1'b1, PAT_E);
        tick();
        idle_bus();
        tick();
        tick();
        checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL abort_busy_ready: got %b want 0", bus.mem_ready); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", bus.mem_ready); end
        checks++; if (bus.is_output_valid !== 1'b0) begin errors++; $display("FAIL abort_ov: got %b want 0", bus.is_output_valid); end
        checks++; if (bus.dout !== '0) begin errors++; $display("FAIL abort_dout: got %h want 0", bus.dout); end
        tick();
        reset = 1'b1;
        tick();
        do_read(32'h30, data, lat, pulses);
        checks++; if (data !== '0) begin errors++; $display("FAIL abort_line3_data: got %h want 0", data); end
        checks++; if (lat !== DLY) begin errors++; $display("FAIL abort_line3_lat: got %0d want %0d", lat, DLY); end
        do_read(32'h50, data, lat, pulses);
        checks++; if (data !== PAT_A5) begin errors++; $display("FAIL abort_line5_kept: got %h want %h", data, PAT_A5); end
    endtask

    task automatic test_unwritten_read;
        logic [W-1:0] data;
        int lat, pulses;
        do_read(32'h120, data, lat, pulses);
        checks++; if (data !== '0) begin errors++; $display("FAIL unwritten_data: got %h want 0", data); end
        checks++; if (lat !== DLY) begin errors++; $display("FAIL unwritten_lat: got %0d want %0d", lat, DLY); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL unwritten_pulses: got %0d want 1", pulses); end
        checks++; if (bus.dout !== '0) begin errors++; $display("FAIL unwritten_dout_hold: got %h want 0", bus.dout); end
    endtask

    task automatic test_busy_ignore;
        logic [W-1:0] data;
        int lat, pulses;
        int stray = 0;
        drive(32'h70, 1'b0, 1'b1, PAT_B);
        tick();
        drive(32'h50, 1'b1, 1'b0, '0);
        for (int e = 1; e <= DLY; e++) begin
            tick();
            if (bus.is_output_valid === 1'b1) stray++;
        end
        idle_bus();
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL busy_wr_done_ready: got %b want 1", bus.mem_ready); end
        for (int e = 0; e < 2; e++) begin
            tick();
            if (bus.is_output_valid === 1'b1) stray++;
            checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL busy_ignored_ready_%0d: got %b want 1", e, bus.mem_ready); end
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL busy_stray_pulses: got %0d want 0", stray); end
        checks++; if (bus.dout !== '0) begin errors++; $display("FAIL busy_dout_unchanged: got %h want 0", bus.dout); end
        do_read(32'h70, data, lat, pulses);
        checks++; if (data !== PAT_B) begin errors++; $display("FAIL busy_line7_data: got %h want %h", data, PAT_B); end
    endtask

    task automatic test_illegal_op;
        logic [W-1:0] data;
        int lat, pulses;
        drive(32'h50, 1'b1, 1'b1, PAT_C);
        tick();
        idle_bus();
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL illegal_rw_ready: got %b want 1", bus.mem_ready); end
`ifdef LINE_MEM_ERR_EN
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL illegal_rw_err: got %b want 1", bus.err); end
`endif
        tick();
        checks++; if (bus.is_output_valid !== 1'b0) begin errors++; $display("FAIL illegal_rw_ov: got %b want 0", bus.is_output_valid); end
`ifdef LINE_MEM_ERR_EN
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL illegal_rw_err_fall: got %b want 0", bus.err); end
`endif
        drive(32'h50, 1'b0, 1'b0, PAT_C);
        tick();
        idle_bus();
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL illegal_none_ready: got %b want 1", bus.mem_ready); end
`ifdef LINE_MEM_ERR_EN
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL illegal_none_err: got %b want 1", bus.err); end
`endif
        tick();
        do_read(32'h50, data, lat, pulses);
        checks++; if (data !== PAT_A5) begin errors++; $display("FAIL illegal_line5_kept: got %h want %h", data, PAT_A5); end
    endtask

    task automatic test_alias;
        logic [W-1:0] data;
        int lat, pulses;
        drive(32'h1050, 1'b0, 1'b1, PAT_C);
        tick();
        idle_bus();
        checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL alias_wr_accept: got %b want 0", bus.mem_ready); end
`ifdef LINE_MEM_ERR_EN
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL alias_err: got %b want 1", bus.err); end
`endif
        repeat (DLY) tick();
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL alias_wr_done: got %b want 1", bus.mem_ready); end
        do_read(32'h0050, data, lat, pulses);
`ifdef LINE_MEM_ERR_EN
        checks++; if (data !== PAT_A5) begin errors++; $display("FAIL alias_line5_data: got %h want %h", data, PAT_A5); end
        do_read(32'h1050, data, lat, pulses);
        checks++; if (data !== '0) begin errors++; $display("FAIL alias_oor_read: got %h want 0", data); end
        checks++; if (lat !== DLY) begin errors++; $display("FAIL alias_oor_lat: got %0d want %0d", lat, DLY); end
`else
        checks++; if (data !== PAT_C) begin errors++; $display("FAIL alias_line5_data: got %h want %h", data, PAT_C); end
`endif
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] data;
        int lat, pulses;
        do_write(32'h90, PAT_D);
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready: got %b want 1", bus.mem_ready); end
        do_read(32'h90, data, lat, pulses);
        checks++; if (data !== PAT_D) begin errors++; $display("FAIL b2b_rd_data: got %h want %h", data, PAT_D); end
        checks++; if (lat !== DLY) begin errors++; $display("FAIL b2b_rd_lat: got %0d want %0d", lat, DLY); end
        drive(32'h90, 1'b1, 1'b0, '0);
        tick();
        idle_bus();
        repeat (DLY) tick();
        checks++; if (bus.is_output_valid !== 1'b1) begin errors++; $display("FAIL b2b_rd2_ov: got %b want 1", bus.is_output_valid); end
        tick();
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL b2b_rd2_ready: got %b want 1", bus.mem_ready); end
        drive(32'h90, 1'b0, 1'b1, PAT_E);
        tick();
        idle_bus();
        checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL b2b_wr2_accept: got %b want 0", bus.mem_ready); end
        repeat (DLY) tick();
        do_read(32'h90, data, lat, pulses);
        checks++; if (data !== PAT_E) begin errors++; $display("FAIL b2b_wr2_data: got %h want %h", data, PAT_E); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        idle_bus();
        test_reset();
        test_write_read();
        test_reset_abort();
        test_unwritten_read();
        test_busy_ignore();
        test_illegal_op();
        test_alias();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_backing_memory.md
# line_backing_memory

Multi-cycle, line-granular backing store that sits directly downstream of the data cache and services its refill reads and write-back writes. It accepts one whole-line request at a time through a valid/ready handshake. It completes the request after a fixed, parameterised latency, so the cache's miss and eviction paths see realistic stall behaviour.

## Interface
- LINE_SIZE, 16: line width in bytes (power of two, ≥4); data ports are LINE_SIZE*8 bits
- NUM_LINES, 256: number of stored lines (power of two)
- DELAY, 50: access latency in cycles (≥1)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted); deassertion sampled synchronously to clk
- is_input_valid  in  1  request present this cycle
- addr  in  32  byte address; line index = addr[log2(LINE_SIZE) +: log2(NUM_LINES)], offset bits ignored
- mem_read  in  1  request is a line read
- mem_write  in  1  request is a line write
- din  in  LINE_SIZE*8  write line data
- is_output_valid  out  1  one-cycle pulse, dout holds read line
- dout  out  LINE_SIZE*8  read line data, registered
- mem_ready  out  1  block can accept a request this cycle
- err  out  1  present only with LINE_MEM_ERR_EN; one-cycle error pulse

## Operation
- FSM states: IDLE, BUSY, RESP. Reset forces IDLE.
- Reset values: mem_ready=1 after reset deasserts, is_output_valid=0, dout=0, err=0, counter=0.
- The line array is not cleared by reset. Simulation power-up contents are all zero.
- Accept condition: IDLE && is_input_valid && (mem_read ^ mem_write). On accept, latch the op, line index and din, load counter=DELAY-1, and go to BUSY.
- is_input_valid with mem_read==mem_write is ignored and the block stays IDLE. Requests while mem_ready=0 are ignored and are not queued.
- BUSY with counter≠0: decrement.
- BUSY with counter==0 on a read: load dout from the array and go to RESP.
- BUSY with counter==0 on a write: store the latched din into the array and go to IDLE.
- RESP: is_output_valid=1 for exactly this cycle, then go to IDLE.
- dout holds its last value until the next read completion. Writes never change dout.
- mem_ready = (state==IDLE), registered-equivalent, with no combinational path from inputs.
- Reset mid-operation aborts the request. A pending write is not committed, and no is_output_valid pulse is produced.
- Address upper bits above the index field are ignored, so addresses alias modulo NUM_LINES*LINE_SIZE.

## Timing
- Accept at edge N.
- Read: dout updates and is_output_valid rises at edge N+DELAY and falls at N+DELAY+1. mem_ready rises at N+DELAY+1.
- Write: the array is updated and mem_ready rises at edge N+DELAY.
- Back-to-back: a new request may be accepted on the first edge at which mem_ready=1.
- Minimum read turnaround is DELAY+1 cycles; minimum write turnaround is DELAY cycles.
- DELAY=1: a read is in BUSY for exactly one cycle.

## Configuration
- Macro: LINE_MEM_ERR_EN.
- When defined, the err port exists. An illegal request while IDLE (is_input_valid with mem_read==mem_write), or an accepted request with any addr bit above the index field set, pulses err for one cycle.
  - Illegal-op requests are still not accepted.
  - Out-of-range requests are accepted and timed normally, but writes are dropped and reads return all-zero dout.
- When undefined, there is no err port, illegal ops are silently ignored, and upper address bits alias.

## Test plan
- Reset with reset=0 mid-BUSY (DELAY=4) -> mem_ready=1, is_output_valid=0, dout=0 immediately; the aborted write to line 3 is absent on a later read.
- Write line 5 (addr=0x50, din=128'hA5…A5) accepted at edge 0, DELAY=4 -> mem_ready low for edges 1-3, high at edge 4. A read of 0x5C then returns A5…A5 with is_output_valid high only between edges 9 and 10 (read accepted at edge 5).
- Read of a never-written line, addr=0x120 -> dout=0 with a single-cycle is_output_valid after DELAY cycles.
- Requests presented while BUSY (read 0x50) -> ignored, with no extra is_output_valid pulse and no state change.
- mem_read=mem_write=1 with is_input_valid -> mem_ready stays 1 and nothing is accepted. With LINE_MEM_ERR_EN, err pulses once.
- Alias check without the macro: write addr=0x1050, read 0x0050 -> same data (NUM_LINES=256, LINE_SIZE=16). With the macro, err pulses and the read returns 0.
